// File: rtl/int_disp_recv_if.sv
// Dispatch-to-int-block handshake bundle: dispatch lanes in, drain lanes out.
// master = dispatch/issue side, slave = int_disp_recv.
`ifndef INTDQ_DISP_WID
`define INTDQ_DISP_WID 4
`endif

interface int_disp_recv_if #(
  parameter int WID     = `INTDQ_DISP_WID,
  parameter int DEQ_WID = 2,
  parameter int INFO_W  = 32,
  parameter int CNT_W   = 5
);
  logic [WID-1:0]                 disp_req;
  logic [WID-1:0]                 disp_rdy;
  logic [WID-1:0][INFO_W-1:0]     disp_info;
  logic [DEQ_WID-1:0]             deq_vld;
  logic [DEQ_WID-1:0]             deq_rdy;
  logic [DEQ_WID-1:0][INFO_W-1:0] deq_info;
  logic [CNT_W-1:0]               count;

  modport master (
    output disp_req, disp_info, deq_rdy,
    input  disp_rdy, deq_vld, deq_info, count
  );

  modport slave (
    input  disp_req, disp_info, deq_rdy,
    output disp_rdy, deq_vld, deq_info, count
  );
endinterface

// File: rtl/int_disp_recv.sv
// Int-block receive FIFO: compacts sparse dispatch lanes into a circular buffer
// and drains it in order. Optional stall counter under INTDQ_RECV_PERF_EN.
`ifndef INTDQ_DISP_WID
`define INTDQ_DISP_WID 4
`endif

module int_disp_recv #(
  parameter int WID     = `INTDQ_DISP_WID,
  parameter int DEPTH   = 16,
  parameter int DEQ_WID = 2,
  parameter int INFO_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  int_disp_recv_if.slave bus
`ifdef INTDQ_RECV_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INFO_W-1:0]           mem [DEPTH];
  logic [PTR_W-1:0]            head_reg, tail_reg;
  logic [CNT_W-1:0]            count_reg, count_next;
  logic [CNT_W-1:0]            free_cnt;
  logic                        space_ok;
  logic [WID-1:0]              disp_rdy_w;
  logic [WID-1:0]              fired;
  logic [WID-1:0][PTR_W-1:0]   lane_off;
  logic [CNT_W-1:0]            enq_n;
  logic [CNT_W-1:0]            deq_n;
  logic [DEQ_WID-1:0]          deq_vld_w;
  logic [DEQ_WID-1:0]          deq_fire;
  logic [DEQ_WID-1:0][INFO_W-1:0] deq_info_w;

  // Admission uses only registered count, so disp_rdy never depends on disp_req.
  assign free_cnt   = CNT_W'(DEPTH) - count_reg;
  assign space_ok   = free_cnt >= CNT_W'(WID);
  assign disp_rdy_w = {WID{space_ok & ~flush & ~rst}};
  assign fired      = bus.disp_req & disp_rdy_w;

  // Each fired lane lands at tail + (number of fired lanes below it).
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WID; i++) begin
      lane_off[i] = acc[PTR_W-1:0];
      acc         = acc + CNT_W'(fired[i]);
    end
    enq_n = acc;
  end

  generate
    for (genvar gi = 0; gi < DEQ_WID; gi++) begin : g_deq
      assign deq_vld_w[gi]  = (count_reg > CNT_W'(gi)) & ~rst;
      assign deq_info_w[gi] = mem[head_reg + PTR_W'(gi)];
    end
  endgenerate

  assign deq_fire = deq_vld_w & bus.deq_rdy;

  // Only the leading run of accepted lanes counts; a gap stops the drain.
  always_comb begin
    logic run;
    run   = 1'b1;
    deq_n = '0;
    for (int i = 0; i < DEQ_WID; i++) begin
      if (run && deq_fire[i]) begin
        deq_n = deq_n + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  assign count_next = count_reg + enq_n - deq_n;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + deq_n[PTR_W-1:0];
      tail_reg  <= tail_reg + enq_n[PTR_W-1:0];
      count_reg <= count_next;
    end
  end

  // Storage is never cleared; pointers alone define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WID; i++) begin
      if (fired[i]) begin
        mem[tail_reg + lane_off[i]] <= bus.disp_info[i];
      end
    end
  end

  assign bus.disp_rdy = disp_rdy_w;
  assign bus.deq_vld  = deq_vld_w;
  assign bus.deq_info = deq_info_w;
  assign bus.count    = count_reg;

`ifdef INTDQ_RECV_PERF_EN
  // Counts dispatch cycles lost to a full buffer; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if ((|bus.disp_req) && !disp_rdy_w[0] && !flush && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/int_disp_recv.md
Name: int_disp_recv

Overview:
- Receiving (exeBlock-side) end of the dispatch-to-int-block handshake: consumes per-lane int_req/int_info and produces int_rdy.
- Buffers accepted microOps in a multi-port circular FIFO.
- Drains the FIFO in program order, up to DEQ_WID ops per cycle, into the int issue queues.
- Decouples dispatch-queue timing from issue-queue backpressure; supports pipeline flush.

Parameters:
- WID, `INTDQ_DISP_WID, number of dispatch lanes per cycle.
- DEPTH, 16, FIFO entries; power of 2; must satisfy DEPTH >= WID.
- DEQ_WID, 2, ops drained per cycle toward issue queues.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all buffered ops (synchronous)
- disp_req  in  WID  per-lane dispatch request (int_req)
- disp_rdy  out  WID  per-lane accept (int_rdy)
- disp_info  in  WID x $bits(microOp_t)  per-lane microOp (int_info)
- deq_vld  out  DEQ_WID  drain lane valid
- deq_rdy  in  DEQ_WID  issue-queue accept per drain lane
- deq_info  out  DEQ_WID x $bits(microOp_t)  microOp at head+i
- count  out  $clog2(DEPTH)+1  occupied entries (registered)

Behaviour:
- State: head, tail pointers of width log2(DEPTH), modulo DEPTH; count register.
- Reset (rst=1 at edge): head=tail=0, count=0.
  - While rst is high, disp_rdy=0 and deq_vld=0.
  - First cycle after reset: disp_rdy = all ones.
- disp_rdy: all WID bits equal (all-or-nothing).
  - disp_rdy = (DEPTH - count >= WID) & ~flush & ~rst.
  - Driven from registered count only; never depends on disp_req, so no combinational loop.
- Enqueue: lane i fires when disp_req[i] & disp_rdy[i].
  - disp_req may be sparse (e.g. 4'b1010).
  - Fired lanes are compacted in ascending lane order into tail, tail+1, ... (wrapping).
  - tail advances by popcount(fired).
  - disp_info is sampled only for fired lanes.
- Dequeue:
  - deq_vld[i] = (count > i) & ~rst.
  - deq_info[i] = entry[(head+i) mod DEPTH]; combinational from registered state.
  - Effective dequeue count n = length of the leading run of (deq_vld & deq_rdy) starting at lane 0.
  - A non-prefix accept (e.g. rdy=2'b10) dequeues 0; the issue side must honour the prefix rule.
  - head advances by n.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - n.
  - Space freed by this cycle's dequeue is visible to disp_rdy only in the next cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH. An enqueue group spanning DEPTH-1 -> 0 is written correctly in the same cycle.
- Full: count == DEPTH. deq_vld remains driven; disp_rdy=0 whenever count > DEPTH-WID.
- Empty: count == 0. deq_vld=0; deq_rdy is ignored.
- flush (priority below rst, above enq/deq):
  - Next state head=tail=0, count=0.
  - disp_rdy=0 during the flush cycle, so no op is accepted.
  - deq_vld stays valid during the flush cycle, but dequeues have no effect on the resulting state.
  - Issue side is flushed by the same signal.
- rst mid-operation: identical to flush; buffered contents are discarded; entry storage is not cleared.
- Latency: op accepted in cycle T appears on deq_vld/deq_info in cycle T+1 at the earliest; no same-cycle bypass.
- Order invariant: dequeue order equals lane-compacted enqueue order across cycles.

Optional Feature:
- Macro: INTDQ_RECV_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt (32 bits).
  - Increments in each cycle where |disp_req & ~disp_rdy[0] & ~rst & ~flush.
  - Saturates at 2^32-1.
  - Cleared by rst only, not by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then single push: rst 1 cycle, then disp_req=4'b1111 with ops A,B,C,D, deq_rdy=0 -> next cycle count=4, deq_vld=2'b11, deq_info={B,A}.
- Sparse compaction: disp_req=4'b1010 (ops X at lane1, Y at lane3) into empty FIFO -> count=2, deq_info[0]=X, deq_info[1]=Y.
- Full backpressure: 3 pushes of 4 with no drain -> count=12, disp_rdy=4'b1111. One more push -> count=16, disp_rdy=0. Drain 2 -> count=14, disp_rdy still 0. Drain 2 more -> count=12, disp_rdy=1 next cycle.
- Wrap and simultaneous: head=14, count=0; push 4 (entries 14,15,0,1) while draining 2/cycle -> order preserved. Same-cycle push 4 + pop 2 -> count increases by exactly 2.
- Non-prefix drain: count=2, deq_rdy=2'b10 -> count unchanged, head unchanged.
- Flush: count=9, flush=1 with disp_req=4'b1111 -> disp_rdy=0 that cycle; next cycle count=0, deq_vld=0, disp_rdy=4'b1111. With INTDQ_RECV_PERF_EN: a stall of 3 cycles at full -> perf_stall_cnt=3, unchanged by the flush.
